alu_nibble_seq: RTL and testbench
=================================

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter SHALL be: NIB, default 4, number of 4-bit nibbles per operation (operand width W = 4*NIB, NIB >= 2).
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request to begin an operation
- op_s  in  4  74181 function select
- op_m  in  1  mode (1 = logic, 0 = arithmetic)
- op_cn  in  1  carry-in to nibble 0, 74181 polarity
- op_a  in  W  operand A
- op_b  in  W  operand B
- alu_s  out  4  select driven to the external 4-bit ALU
- alu_m  out  1  mode driven to the ALU
- alu_a  out  4  current A nibble to the ALU
- alu_b  out  4  current B nibble to the ALU
- alu_cn  out  1  current carry-in to the ALU
- alu_f  in  4  ALU nibble result (combinational from alu_* outputs)
- alu_cn_4  in  1  ALU nibble carry-out
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  W  assembled W-bit result
- cout  out  1  carry-out of the top nibble, 74181 polarity
- zero  out  1  result == 0

Function
REQ-004 FSM SHALL have states IDLE, RUN, DONE; nibble index idx SHALL count 0..NIB-1.
REQ-005 In IDLE, start=1 SHALL latch op_s, op_m, op_cn, op_a, op_b, set carry register to op_cn, idx to 0, and move to RUN.
REQ-006 start SHALL be ignored in RUN and DONE; latched operands SHALL not change until the next accepted start.
REQ-007 In RUN, alu_a/alu_b SHALL equal latched A/B bits [4*idx+3:4*idx], alu_s/alu_m the latched select/mode, alu_cn the carry register.
REQ-008 Each RUN cycle edge SHALL write alu_f into result[4*idx+3:4*idx], load alu_cn_4 into the carry register, and increment idx.
REQ-009 The RUN edge with idx = NIB-1 SHALL also load cout from alu_cn_4 and move to DONE; idx SHALL not wrap into a fifth capture.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 Latency: start accepted at edge k -> done high in the cycle after edge k+NIB; busy high in RUN and DONE only.
REQ-012 Carry SHALL chain between nibbles in both modes; in logic mode cout SHALL still report the final alu_cn_4 unmodified.
REQ-013 result, cout, zero SHALL hold their values from DONE until the next accepted start; result nibbles SHALL update progressively during RUN.
REQ-014 zero SHALL be combinational from result.
REQ-015 In IDLE, alu_a/alu_b SHALL be nibble 0 of the latched operands and alu_cn the carry register (no gating required).
REQ-016 start asserted in the same cycle DONE is active SHALL be ignored; a new start SHALL be accepted from IDLE on the following cycle.

Reset
REQ-017 rst=1 at any edge, including mid-RUN, SHALL force IDLE, idx=0, busy=0, done=0, result=0, cout=1, carry register=1, latched operands/select/mode=0; no done pulse SHALL follow an aborted operation.
REQ-018 rst SHALL take priority over start in the same cycle.

Verification (NIB=4, bench models the 74181 combinationally on alu_*)
REQ-019 op_m=0, op_s=1001, op_cn=1, A=0x00FF, B=0x0001, start -> done 5 cycles later (after edge k+4), result=0x0100, cout=1, zero=0.
REQ-020 op_m=0, op_s=1001, op_cn=1, A=0xFFFF, B=0x0001 -> result=0x0000, cout=0, zero=1.
REQ-021 op_m=0, op_s=0110, op_cn=0, A=0x1234, B=0x0034 -> result=0x1200, cout=0 (no borrow).
REQ-022 op_m=1, op_s=0110, A=0xA5A5, B=0xFFFF -> result=0x5A5A; alu_s=0110, alu_m=1 throughout RUN.
REQ-023 start pulsed again during RUN with different operands -> ignored, result of first operation unchanged, exactly one done pulse.
REQ-024 rst asserted at the second RUN cycle -> next cycle busy=0, result=0, cout=1, no done; a subsequent start completes normally.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq
// Sequences a W-bit (W = 4*NIB) operation through an external 4-bit
// 74181-style ALU, one nibble per clock, least significant nibble first.
// The ALU carry-out of each nibble is fed back as the carry-in of the next.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin an operation (accepted only in IDLE)
//   op_s, op_m, op_cn   74181 select, mode (1 = logic), carry-in (active low)
//   op_a, op_b          W-bit operands
//   alu_s, alu_m        select / mode presented to the external ALU
//   alu_a, alu_b        current operand nibbles presented to the ALU
//   alu_cn              current carry-in presented to the ALU
//   alu_f, alu_cn_4     ALU nibble result and carry-out (combinational)
//   busy                high in RUN and DONE
//   done                one-cycle completion pulse
//   result, cout, zero  assembled result, final carry-out, result == 0
module alu_nibble_seq #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_s,
  input  logic               op_m,
  input  logic               op_cn,
  input  logic [4*NIB-1:0]   op_a,
  input  logic [4*NIB-1:0]   op_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic               alu_cn,
  input  logic [3:0]         alu_f,
  input  logic               alu_cn_4,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   result,
  output logic               cout,
  output logic               zero
);

  localparam int W  = 4 * NIB;
  localparam int IW = $clog2(NIB);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [IW-1:0]   idx_r;
  logic [3:0]      s_r;
  logic            m_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
  logic [W-1:0]    result_r;
  logic            cout_r;

  logic            accept_s;
  logic            step_s;
  logic            last_s;

  // Next-state and datapath strobes for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; it is seen again in IDLE.
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register, operand latches, nibble capture and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= IDX_ZERO;
      s_r      <= 4'b0000;
      m_r      <= 1'b0;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      carry_r  <= 1'b1;
      result_r <= {W{1'b0}};
      cout_r   <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        s_r     <= op_s;
        m_r     <= op_m;
        a_r     <= op_a;
        b_r     <= op_b;
        carry_r <= op_cn;
        idx_r   <= IDX_ZERO;
      end else if (step_s) begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_r == IW'(i)) begin
            result_r[4*i +: 4] <= alu_f;
          end
        end
        // Carry chains in both modes; in logic mode the ALU ignores it for F.
        carry_r <= alu_cn_4;
        if (last_s) begin
          cout_r <= alu_cn_4;
          // Parking idx at 0 keeps nibble 0 on alu_a/alu_b while idle.
          idx_r  <= IDX_ZERO;
        end else begin
          idx_r  <= idx_r + IDX_ONE;
        end
      end
    end
  end

  assign alu_s  = s_r;
  assign alu_m  = m_r;
  assign alu_a  = a_r[{idx_r, 2'b00} +: 4];
  assign alu_b  = b_r[{idx_r, 2'b00} +: 4];
  assign alu_cn = carry_r;
  assign busy   = (state_r != IDLE);
  assign done   = (state_r == DONE);
  assign result = result_r;
  assign cout   = cout_r;
  assign zero   = (result_r == {W{1'b0}});

endmodule

// File: tb/tb_alu_nibble_seq.sv
module tb_alu_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    op_s;
  logic          op_m;
  logic          op_cn;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [3:0]    alu_s;
  logic          alu_m;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic          alu_cn;
  logic [3:0]    alu_f;
  logic          alu_cn_4;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          zero;

  alu_nibble_seq #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_s(op_s), .op_m(op_m), .op_cn(op_cn), .op_a(op_a), .op_b(op_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn_4(alu_cn_4),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic [W-1:0] res;
    logic         cout;
    int           dcyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   run_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // 74181 logic-mode functions (active-high data), any width up to W.
  function automatic logic [W-1:0] logic_fn(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      4'd0:    return ~a;
      4'd1:    return ~(a | b);
      4'd2:    return ~a & b;
      4'd3:    return {W{1'b0}};
      4'd4:    return ~(a & b);
      4'd5:    return ~b;
      4'd6:    return a ^ b;
      4'd7:    return a & ~b;
      4'd8:    return ~a | b;
      4'd9:    return ~(a ^ b);
      4'd10:   return b;
      4'd11:   return a & b;
      4'd12:   return {W{1'b1}};
      4'd13:   return a | ~b;
      4'd14:   return a | b;
      default: return a;
    endcase
  endfunction

  // Whole-word reference: arithmetic is X + Y + carry over W bits, where X/Y
  // are the datasheet operand terms (e.g. S=1001 gives (A|B)+(A&B) = A+B).
  // Returns {cout (active low), result}.
  function automatic logic [W:0] ref_model(input logic [3:0] s, input logic m, input logic cn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    logic [W:0]   sum;
    x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cn};
    return {~sum[W], (m ? logic_fn(s, a, b) : sum[W-1:0])};
  endfunction

  // External 4-bit 74181 model driven by the DUT's alu_* outputs.
  logic [3:0]   x4, y4;
  logic [4:0]   sum4;
  logic [W-1:0] lf_w;
  always_comb begin
    x4       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y4       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sum4     = {1'b0, x4} + {1'b0, y4} + {4'b0000, ~alu_cn};
    lf_w     = logic_fn(alu_s, {{(W-4){1'b0}}, alu_a}, {{(W-4){1'b0}}, alu_b});
    alu_cn_4 = ~sum4[4];
    alu_f    = alu_m ? lf_w[3:0] : sum4[3:0];
  end

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int n);
    logic [W-1:0] t;
    t = v >> (4 * n);
    return t[3:0];
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] s, input logic m, input logic cn,
                                  input logic [W-1:0] a, input logic [W-1:0] b, input int dcyc);
    exp_t e;
    logic [W:0] r;
    r      = ref_model(s, m, cn, a, b);
    e.a    = a;
    e.b    = b;
    e.s    = s;
    e.m    = m;
    e.res  = r[W-1:0];
    e.cout = r[W];
    e.dcyc = dcyc;
    return e;
  endfunction

  // Monitor: checks ALU drive during RUN and pops the scoreboard on done.
  always @(negedge clk) begin
    if (rst) begin
      run_n = 0;
    end else if (done) begin
      run_n = 0;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("cout", 32'(cout), 32'(mon_e.cout));
        chk("zero", 32'(zero), 32'(mon_e.res == {W{1'b0}}));
        chk("done_cycle", 32'(cyc), 32'(mon_e.dcyc));
      end
    end else if (busy && q.size() > 0) begin
      chk("alu_sel_run", 32'({alu_m, alu_s}), 32'({q[0].m, q[0].s}));
      chk("alu_a_run", 32'(alu_a), 32'(nib(q[0].a, run_n)));
      chk("alu_b_run", 32'(alu_b), 32'(nib(q[0].b, run_n)));
      run_n = run_n + 1;
    end
  end

  // Called at a negedge with the DUT idle; returns at the next negedge.
  task automatic issue(input logic [3:0] s, input logic m, input logic cn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    op_s  = s;
    op_m  = m;
    op_cn = cn;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    q.push_back(mk_exp(s, m, cn, a, b, cyc + 1 + NIB));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    op_s  = 4'h0;
    op_m  = 1'b0;
    op_cn = 1'b1;
    op_a  = {W{1'b0}};
    op_b  = {W{1'b0}};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd1);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_alu_cn", 32'(alu_cn), 32'd1);
    chk("rst_alu_sel", 32'({alu_m, alu_s}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: A+B, A+B overflow, A-B with carry-in, XOR in logic mode.
    issue(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001); wait_idle();
    chk("add_result_hold", 32'(result), 32'h0100);
    chk("add_cout_hold", 32'(cout), 32'd1);
    issue(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001); wait_idle();
    chk("ovf_zero_hold", 32'(zero), 32'd1);
    issue(4'b0110, 1'b0, 1'b0, 16'h1234, 16'h0034); wait_idle();
    chk("sub_result_hold", 32'(result), 32'h1200);
    issue(4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'hFFFF); wait_idle();
    chk("xor_result_hold", 32'(result), 32'h5A5A);

    // start pulsed during RUN with other operands must be ignored.
    issue(4'b1001, 1'b0, 1'b0, 16'h1111, 16'h2222);
    op_s  = 4'b0110;
    op_m  = 1'b1;
    op_a  = 16'hDEAD;
    op_b  = 16'hBEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignored_start_result", 32'(result), 32'h3334);

    // start held through DONE: accepted only from IDLE one cycle later.
    issue(4'b0000, 1'b0, 1'b1, 16'h4321, 16'h0000);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_seen", 32'(done), 32'd1);
    op_s  = 4'b1001;
    op_m  = 1'b0;
    op_cn = 1'b1;
    op_a  = 16'h0F0F;
    op_b  = 16'h0101;
    start = 1'b1;
    q.push_back(mk_exp(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h0101, cyc + 2 + NIB));
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the second RUN cycle aborts without a done pulse.
    op_s  = 4'b1001;
    op_m  = 1'b0;
    op_cn = 1'b1;
    op_a  = 16'h7777;
    op_b  = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd1);
    chk("abort_alu_cn", 32'(alu_cn), 32'd1);
    repeat (8) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 32'd0);
    issue(4'b1001, 1'b0, 1'b1, 16'h7777, 16'h1111); wait_idle();

    // Randomized operations against the whole-word reference.
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            16'($urandom), 16'($urandom));
      if (($urandom_range(3, 0)) == 0) begin
        wait_idle();
      end else begin
        n = 0;
        while ((busy || done) && n < 20) begin
          @(negedge clk);
          n++;
        end
      end
    end

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
